// File: rtl/rv64_alu_rf.sv
// -----------------------------------------------------------------------------
// rv64_alu_rf : datapath block for the single-cycle RV64 core.
//
// Contains three modules:
//   alu         - combinational 64-bit ALU (zero, add, unsigned set-less-than, sub)
//   regfile     - 32 x 64-bit integer register file, x0 hardwired to zero,
//                 two asynchronous read ports and one synchronous write port
//   rv64_alu_rf - wrapper placing both under one clock / synchronous reset
//
// rv64_alu_rf ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (clears the register file)
//   alu_src1   in   ALU operand A (rs1 value or PC)
//   alu_src2   in   ALU operand B (sign-extended immediate)
//   alu_op     in   2'b00 zero, 2'b01 add, 2'b10 sltu, 2'b11 sub
//   alu_result out  ALU result, combinational
//   rf_raddr1  in   read port 1 address
//   rf_rdata1  out  read port 1 data, combinational
//   rf_raddr2  in   read port 2 address
//   rf_rdata2  out  read port 2 data, combinational
//   rf_we      in   write enable
//   rf_waddr   in   write address
//   rf_wdata   in   write data
// -----------------------------------------------------------------------------

module alu #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [1:0]      aluop,
   output logic [XLEN-1:0] result
);

   // Operation select; add/sub wrap modulo 2^XLEN, the compare is unsigned.
   always_comb begin
      result = {XLEN{1'b0}};
      case (aluop)
         2'b00:   result = {XLEN{1'b0}};
         2'b01:   result = src1 + src2;
         2'b10:   result = {{(XLEN-1){1'b0}}, (src1 < src2)};
         2'b11:   result = src1 - src2;
         default: result = {XLEN{1'b0}};
      endcase
   end

endmodule

module regfile #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   raddr1,
   output logic [XLEN-1:0] rdata1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata2,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] regs_q [NREG];
   logic            wr_en_d;

   // A write is performed only for a non-zero destination; x0 stays zero.
   always_comb begin
      wr_en_d = 1'b0;
      if (we && (waddr != {AW{1'b0}})) begin
         wr_en_d = 1'b1;
      end else begin
         wr_en_d = 1'b0;
      end
   end

   // Register storage: reset wins over a simultaneous write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {XLEN{1'b0}};
         end
      end else if (wr_en_d) begin
         regs_q[waddr] <= wdata;
      end
   end

   // Asynchronous read ports without write bypass; address 0 reads zero
   // regardless of what the x0 storage slot holds.
   always_comb begin
      rdata1 = {XLEN{1'b0}};
      rdata2 = {XLEN{1'b0}};
      if (raddr1 != {AW{1'b0}}) begin
         rdata1 = regs_q[raddr1];
      end else begin
         rdata1 = {XLEN{1'b0}};
      end
      if (raddr2 != {AW{1'b0}}) begin
         rdata2 = regs_q[raddr2];
      end else begin
         rdata2 = {XLEN{1'b0}};
      end
   end

endmodule

module rv64_alu_rf #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] alu_src1,
   input  logic [XLEN-1:0] alu_src2,
   input  logic [1:0]      alu_op,
   output logic [XLEN-1:0] alu_result,
   input  logic [AW-1:0]   rf_raddr1,
   output logic [XLEN-1:0] rf_rdata1,
   input  logic [AW-1:0]   rf_raddr2,
   output logic [XLEN-1:0] rf_rdata2,
   input  logic            rf_we,
   input  logic [AW-1:0]   rf_waddr,
   input  logic [XLEN-1:0] rf_wdata
);

   alu #(
      .XLEN (XLEN)
   ) u_alu (
      .src1   (alu_src1),
      .src2   (alu_src2),
      .aluop  (alu_op),
      .result (alu_result)
   );

   regfile #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (rf_raddr1),
      .rdata1 (rf_rdata1),
      .raddr2 (rf_raddr2),
      .rdata2 (rf_rdata2),
      .we     (rf_we),
      .waddr  (rf_waddr),
      .wdata  (rf_wdata)
   );

endmodule

// File: tb/tb_rv64_alu_rf.sv
// -----------------------------------------------------------------------------
// tb_rv64_alu_rf : self-checking bench for rv64_alu_rf. Directed cases for
// reset, x0, read-during-write and ALU corner values, then randomized cycles
// compared against a behavioural array/arithmetic reference model.
// -----------------------------------------------------------------------------

module tb_rv64_alu_rf;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] alu_src1;
   logic [63:0] alu_src2;
   logic [1:0]  alu_op;
   logic [63:0] alu_result;
   logic [4:0]  rf_raddr1;
   logic [63:0] rf_rdata1;
   logic [4:0]  rf_raddr2;
   logic [63:0] rf_rdata2;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;

   int checks   = 0;
   int failures = 0;

   logic [63:0] model [32];

   rv64_alu_rf dut (
      .clk        (clk),
      .rst        (rst),
      .alu_src1   (alu_src1),
      .alu_src2   (alu_src2),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .rf_raddr1  (rf_raddr1),
      .rf_rdata1  (rf_rdata1),
      .rf_raddr2  (rf_raddr2),
      .rf_rdata2  (rf_rdata2),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rf_ref(input logic [4:0] a);
      return (a == 5'd0) ? 64'h0 : model[a];
   endfunction

   function automatic logic [63:0] alu_ref(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      case (op)
         2'b01:   return a + b;
         2'b10:   return (a < b) ? 64'd1 : 64'd0;
         2'b11:   return a - b;
         default: return 64'd0;
      endcase
   endfunction

   // Advance one clock edge, updating the reference model with the inputs
   // present at the edge, then step just past it.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = 64'h0;
      end else if (rf_we && rf_waddr != 5'd0) begin
         model[rf_waddr] = rf_wdata;
      end
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         rf_raddr1 = i[4:0];
         rf_raddr2 = 5'(31 - i);
         #1;
         check_val(tag, rf_rdata1, 64'h0);
         check_val(tag, rf_rdata2, 64'h0);
      end
   endtask

   logic [1:0]  t_op [10];
   logic [63:0] t_a  [10];
   logic [63:0] t_b  [10];
   logic [63:0] t_e  [10];

   initial begin
      rst = 1'b1; rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 64'h0;
      rf_raddr1 = 5'd0; rf_raddr2 = 5'd0;
      alu_src1 = 64'h0; alu_src2 = 64'h0; alu_op = 2'b00;
      for (int i = 0; i < 32; i++) model[i] = 64'h0;

      // Reset state
      tick();
      rst = 1'b0;
      check_all_zero("reset_state");

      // Reset beats a simultaneous write
      rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 64'hDEAD;
      tick();
      rf_we = 1'b0; rf_raddr1 = 5'd5; #1;
      check_val("x5_written", rf_rdata1, 64'hDEAD);
      rst = 1'b1; rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 64'h1;
      tick();
      rst = 1'b0; rf_we = 1'b0; rf_raddr1 = 5'd5; #1;
      check_val("x5_after_reset", rf_rdata1, 64'h0);
      check_all_zero("all_after_reset");

      // x0 ignores writes; x31 readable on both ports
      rf_we = 1'b1; rf_waddr = 5'd0; rf_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      rf_we = 1'b0; rf_raddr1 = 5'd0; #1;
      check_val("x0_write_ignored", rf_rdata1, 64'h0);
      rf_we = 1'b1; rf_waddr = 5'd31; rf_wdata = 64'h1234567887654321;
      tick();
      rf_we = 1'b0; rf_raddr1 = 5'd31; rf_raddr2 = 5'd31; #1;
      check_val("x31_port1", rf_rdata1, 64'h1234567887654321);
      check_val("x31_port2", rf_rdata2, 64'h1234567887654321);

      // Read during write: old value before the edge, new value after
      rf_we = 1'b1; rf_waddr = 5'd7; rf_wdata = 64'hA5; rf_raddr1 = 5'd7; #1;
      check_val("rdw_before_edge", rf_rdata1, 64'h0);
      tick();
      check_val("rdw_after_edge", rf_rdata1, 64'hA5);
      rf_we = 1'b0; rf_wdata = 64'hFF;
      tick();
      check_val("x7_hold_we0", rf_rdata1, 64'hA5);

      // ALU directed corner cases
      t_op[0] = 2'b01; t_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; t_b[0] = 64'd1;                  t_e[0] = 64'h0;
      t_op[1] = 2'b01; t_a[1] = 64'h8000_0000;           t_b[1] = 64'hFFFF_FFFF_FFFF_FFF0; t_e[1] = 64'h7FFF_FFF0;
      t_op[2] = 2'b10; t_a[2] = 64'd1;                   t_b[2] = 64'd2;                  t_e[2] = 64'd1;
      t_op[3] = 2'b10; t_a[3] = 64'd2;                   t_b[3] = 64'd1;                  t_e[3] = 64'd0;
      t_op[4] = 2'b10; t_a[4] = 64'd5;                   t_b[4] = 64'd5;                  t_e[4] = 64'd0;
      t_op[5] = 2'b10; t_a[5] = 64'd1;                   t_b[5] = 64'hFFFF_FFFF_FFFF_FFFF; t_e[5] = 64'd1;
      t_op[6] = 2'b11; t_a[6] = 64'd0;                   t_b[6] = 64'd1;                  t_e[6] = 64'hFFFF_FFFF_FFFF_FFFF;
      t_op[7] = 2'b00; t_a[7] = 64'hDEAD_BEEF_0000_1234; t_b[7] = 64'h55;                 t_e[7] = 64'h0;
      t_op[8] = 2'b11; t_a[8] = 64'd100;                 t_b[8] = 64'd58;                 t_e[8] = 64'd42;
      t_op[9] = 2'b01; t_a[9] = 64'h1234;                t_b[9] = 64'h4321;               t_e[9] = 64'h5555;
      for (int i = 0; i < 10; i++) begin
         alu_op = t_op[i]; alu_src1 = t_a[i]; alu_src2 = t_b[i]; #1;
         check_val($sformatf("alu_dir%0d", i), alu_result, t_e[i]);
      end

      // Randomized cycles against the reference model
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 39) == 0);
         rf_we     = $urandom_range(0, 1) == 1;
         rf_waddr  = 5'($urandom_range(0, 31));
         rf_wdata  = {$urandom(), $urandom()};
         rf_raddr1 = ($urandom_range(0, 3) == 0) ? rf_waddr : 5'($urandom_range(0, 31));
         rf_raddr2 = 5'($urandom_range(0, 31));
         alu_op    = 2'($urandom_range(0, 3));
         alu_src1  = {$urandom(), $urandom()};
         alu_src2  = ($urandom_range(0, 7) == 0) ? alu_src1 : {$urandom(), $urandom()};
         #1;
         check_val("rand_rd1", rf_rdata1, rf_ref(rf_raddr1));
         check_val("rand_rd2", rf_rdata2, rf_ref(rf_raddr2));
         check_val("rand_alu", alu_result, alu_ref(alu_op, alu_src1, alu_src2));
         tick();
         check_val("rand_rd1_post", rf_rdata1, rf_ref(rf_raddr1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
